// File: rtl/memory_stage.sv
// memory_stage: EX/MEM -> MEM/WB stage with a wait-stated data memory (optional MEM_STAGE_BOUNDS_CHECK_EN)
module memory_stage #(
    parameter int ADDR_WIDTH  = 11,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alu_result_from_ex,
    input  logic [2:0]  ccr_from_ex,
    input  logic        RegWrite_from_ex,
    input  logic [2:0]  reg_write_address_from_ex,
    input  logic [15:0] sign_extend_from_ex,
    input  logic        write_back_select_from_ex,
    input  logic [15:0] reg_file_read_data1_from_ex,
    input  logic [15:0] reg_file_read_data2_from_ex,
    input  logic        memRead_from_ex,
    input  logic        memWrite_from_ex,
    output logic        mem_stall,
    output logic        RegWrite_to_wb,
    output logic [2:0]  reg_write_address_to_wb,
    output logic [15:0] write_back_data_to_wb,
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    output logic        mem_addr_fault,
`endif
    output logic [2:0]  ccr_to_wb
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [2:0] LAT = 3'(MEM_LATENCY);
    state_t state;
    logic [2:0] cnt;
    logic [15:0] mem [2**ADDR_WIDTH];
    logic mem_op, complete, capture, oob, unused_ok;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0] load_data, wb_data;
    assign mem_op = memRead_from_ex | memWrite_from_ex;
    assign addr = alu_result_from_ex[ADDR_WIDTH-1:0];
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    assign oob = |alu_result_from_ex[15:ADDR_WIDTH];
`else
    assign oob = 1'b0;
`endif
    assign unused_ok = ^{reg_file_read_data1_from_ex, alu_result_from_ex[15:ADDR_WIDTH]};
    assign complete = mem_op && (state == WAIT ? cnt == LAT : LAT == 3'd0);
    assign capture = complete || (state == IDLE && !mem_op);
    assign mem_stall = !reset && !capture;
    assign load_data = oob ? 16'h0 : mem[addr];
    assign wb_data = memRead_from_ex ? load_data
                   : (write_back_select_from_ex ? sign_extend_from_ex : alu_result_from_ex);
    // wait-state FSM plus the MEM/WB register, which loads a bubble while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 3'd0;
            RegWrite_to_wb <= 1'b0;
            reg_write_address_to_wb <= 3'd0;
            write_back_data_to_wb <= 16'h0;
            ccr_to_wb <= 3'd0;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
            mem_addr_fault <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                if (mem_op && LAT != 3'd0) begin
                    state <= WAIT;
                    cnt <= 3'd1;
                end
            end else if (cnt == LAT) begin
                state <= IDLE;
                cnt <= 3'd0;
            end else begin
                cnt <= cnt + 3'd1;
            end
            RegWrite_to_wb <= capture && RegWrite_from_ex;
            reg_write_address_to_wb <= capture ? reg_write_address_from_ex : 3'd0;
            write_back_data_to_wb <= capture ? wb_data : 16'h0;
            ccr_to_wb <= capture ? ccr_from_ex : 3'd0;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
            mem_addr_fault <= complete && oob;
`endif
        end
    end
    // store lands once, on the completion edge; reset cancels a pending store
    always_ff @(posedge clk) begin
        if (complete && memWrite_from_ex && !oob && !reset)
            mem[addr] <= reg_file_read_data2_from_ex;
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage at MEM_LATENCY 2 and 0
module tb_memory_stage;
    logic clk = 1'b0;
    logic reset;
    logic [15:0] alu, imm, d1, d2;
    logic [2:0] ccr, rd;
    logic rw, wbs, mr, mw;
    logic stall2, rw2, stall0, rw0;
    logic [2:0] rd2, ccr2, rd0, ccr0;
    logic [15:0] wb2, wb0;
    logic flt2, flt0;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    memory_stage #(.ADDR_WIDTH(11), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .alu_result_from_ex(alu), .ccr_from_ex(ccr),
        .RegWrite_from_ex(rw), .reg_write_address_from_ex(rd), .sign_extend_from_ex(imm),
        .write_back_select_from_ex(wbs), .reg_file_read_data1_from_ex(d1),
        .reg_file_read_data2_from_ex(d2), .memRead_from_ex(mr), .memWrite_from_ex(mw),
        .mem_stall(stall2), .RegWrite_to_wb(rw2), .reg_write_address_to_wb(rd2),
        .write_back_data_to_wb(wb2),
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        .mem_addr_fault(flt2),
`endif
        .ccr_to_wb(ccr2));

    memory_stage #(.ADDR_WIDTH(11), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .alu_result_from_ex(alu), .ccr_from_ex(ccr),
        .RegWrite_from_ex(rw), .reg_write_address_from_ex(rd), .sign_extend_from_ex(imm),
        .write_back_select_from_ex(wbs), .reg_file_read_data1_from_ex(d1),
        .reg_file_read_data2_from_ex(d2), .memRead_from_ex(mr), .memWrite_from_ex(mw),
        .mem_stall(stall0), .RegWrite_to_wb(rw0), .reg_write_address_to_wb(rd0),
        .write_back_data_to_wb(wb0),
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        .mem_addr_fault(flt0),
`endif
        .ccr_to_wb(ccr0));

`ifndef MEM_STAGE_BOUNDS_CHECK_EN
    assign flt2 = 1'b0;
    assign flt0 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present one op; z selects the MEM_LATENCY=0 instance
    task automatic run(input string tag, input bit z, input logic [15:0] a, input logic [2:0] c,
                       input logic w, input logic [2:0] r, input logic [15:0] im, input logic s,
                       input logic [15:0] sd, input logic rdq, input logic wrq,
                       input int stalls, input logic [15:0] exp_data);
        @(negedge clk);
        alu = a; ccr = c; rw = w; rd = r; imm = im; wbs = s; d2 = sd; mr = rdq; mw = wrq;
        d1 = 16'hDEAD;
        #1;
        for (int i = 0; i < stalls; i++) begin
            chk({tag, "_stall"}, 16'(z ? stall0 : stall2), 16'd1);
            @(posedge clk); #1;
            chk({tag, "_bubble_rw"}, 16'(z ? rw0 : rw2), 16'd0);
            chk({tag, "_bubble_data"}, z ? wb0 : wb2, 16'h0);
            chk({tag, "_bubble_ccr"}, 16'(z ? ccr0 : ccr2), 16'd0);
            chk({tag, "_bubble_fault"}, 16'(z ? flt0 : flt2), 16'd0);
        end
        chk({tag, "_nostall"}, 16'(z ? stall0 : stall2), 16'd0);
        @(posedge clk); #1;
        chk({tag, "_rw"}, 16'(z ? rw0 : rw2), 16'(w));
        chk({tag, "_rd"}, 16'(z ? rd0 : rd2), 16'(r));
        chk({tag, "_data"}, z ? wb0 : wb2, exp_data);
        chk({tag, "_ccr"}, 16'(z ? ccr0 : ccr2), 16'(c));
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        chk({tag, "_fault"}, 16'(z ? flt0 : flt2), 16'((rdq | wrq) && (a[15:11] != 5'd0)));
`endif
    endtask

    initial begin
        reset = 1'b1;
        alu = 16'h0; imm = 16'h0; d1 = 16'h0; d2 = 16'h0; ccr = 3'd0; rd = 3'd0;
        rw = 1'b1; wbs = 1'b0; mr = 1'b1; mw = 1'b0;
        #1;
        chk("rst_stall2", 16'(stall2), 16'd0);
        chk("rst_stall0", 16'(stall0), 16'd0);
        @(posedge clk); #1;
        chk("rst_rw", 16'(rw2), 16'd0);
        chk("rst_rd", 16'(rd2), 16'd0);
        chk("rst_data", wb2, 16'h0);
        chk("rst_ccr", 16'(ccr2), 16'd0);
        chk("rst_fault", 16'(flt2), 16'd0);
        chk("rst_data0", wb0, 16'h0);
        @(negedge clk);
        reset = 1'b0; mr = 1'b0; rw = 1'b0;
        run("alu",      0, 16'h1234, 3'b001, 1, 3'd1, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h1234);
        run("imm",      0, 16'h00FF, 3'b010, 1, 3'd2, 16'hFFF0, 1, 16'h0, 0, 0, 0, 16'hFFF0);
        run("st5",      0, 16'h0005, 3'b000, 0, 3'd0, 16'h0000, 0, 16'hBEEF, 0, 1, 2, 16'h0005);
        run("ld5",      0, 16'h0005, 3'b100, 1, 3'd3, 16'h0000, 0, 16'h0, 1, 0, 2, 16'hBEEF);
        run("st7",      0, 16'h0007, 3'b000, 0, 3'd0, 16'h0000, 0, 16'h0011, 0, 1, 2, 16'h0007);
        run("rmw7",     0, 16'h0007, 3'b011, 1, 3'd4, 16'h0000, 0, 16'h0022, 1, 1, 2, 16'h0011);
        run("ld7",      0, 16'h0007, 3'b000, 1, 3'd4, 16'h0000, 0, 16'h0, 1, 0, 2, 16'h0022);
        run("st3",      0, 16'h0003, 3'b000, 0, 3'd0, 16'h0000, 0, 16'h5555, 0, 1, 2, 16'h0003);
        @(negedge clk);
        alu = 16'h0003; d2 = 16'hAAAA; mw = 1'b1; mr = 1'b0; rw = 1'b1; rd = 3'd6;
        @(posedge clk); #1;
        chk("rstw_stall_before", 16'(stall2), 16'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstw_stall", 16'(stall2), 16'd0);
        chk("rstw_rw", 16'(rw2), 16'd0);
        chk("rstw_data", wb2, 16'h0);
        chk("rstw_rd", 16'(rd2), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mw = 1'b0;
        run("ld3",      0, 16'h0003, 3'b000, 1, 3'd6, 16'h0000, 0, 16'h0, 1, 0, 2, 16'h5555);
        run("st805",    0, 16'h0805, 3'b000, 0, 3'd0, 16'h0000, 0, 16'h9999, 0, 1, 2, 16'h0805);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        run("ld5b",     0, 16'h0005, 3'b000, 1, 3'd1, 16'h0000, 0, 16'h0, 1, 0, 2, 16'hBEEF);
        run("ld805",    0, 16'h0805, 3'b000, 1, 3'd1, 16'h0000, 0, 16'h0, 1, 0, 2, 16'h0000);
`else
        run("ld5b",     0, 16'h0005, 3'b000, 1, 3'd1, 16'h0000, 0, 16'h0, 1, 0, 2, 16'h9999);
        run("ld805",    0, 16'h0805, 3'b000, 1, 3'd1, 16'h0000, 0, 16'h0, 1, 0, 2, 16'h9999);
`endif
        run("l0_st_a",  1, 16'h07FF, 3'b001, 0, 3'd0, 16'h0000, 0, 16'h1357, 0, 1, 0, 16'h07FF);
        run("l0_ld_a",  1, 16'h07FF, 3'b000, 1, 3'd5, 16'h0000, 0, 16'h0, 1, 0, 0, 16'h1357);
        run("l0_st_b",  1, 16'h07FF, 3'b000, 0, 3'd0, 16'h0000, 0, 16'h2468, 0, 1, 0, 16'h07FF);
        run("l0_ld_b",  1, 16'h07FF, 3'b110, 1, 3'd7, 16'h0000, 0, 16'h0, 1, 0, 0, 16'h2468);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
